// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem: AHB-Lite slave memory with wait states, ERROR response and read-after-write forwarding
// Ports:
//   hclk, hreset_n        clock (rising edge), asynchronous active-low reset
//   hsel, haddr, htrans   slave select, byte address, transfer type
//   hwrite, hsize, hburst direction, log2 transfer bytes, burst type (ignored)
//   hwdata, hready        write data (data phase), bus-level ready in
//   hreadyout, hrdata     slave ready, registered read data
//   hresp                 0 OKAY, 1 ERROR
module ahb_lite_slave_mem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata,
    output logic              hresp
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic               a_write;
    logic [2:0]         a_size;
    logic [OFF_W-1:0]   a_off;
    logic [IDX_W-1:0]   a_idx;
    logic [DATA_W-1:0]  mem [MEM_DEPTH];
    logic [DATA_W-1:0]  wmask;
    logic [DATA_W-1:0]  rd_word;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         amask;
    logic               err;
    logic               accept;
    logic               fwd;
    logic               unused_ok;

    assign unused_ok = ^{hburst, htrans[0]};
    assign idx       = haddr[OFF_W +: IDX_W];
    assign amask     = (8'd1 << hsize) - 8'd1;
    assign err       = (hsize > 3'(OFF_W))
                     | (|({5'd0, haddr[2:0]} & amask))
                     | (64'(haddr) >= 64'(MEM_DEPTH) * 64'(NB));
    // hreadyout high means our previous data phase is over, so a new address phase may be taken
    assign accept    = hsel & hready & htrans[1] & hreadyout;
    // a read accepted while a write to the same word is finishing sees that write's lanes
    assign fwd       = (state == S_LAST) & a_write & (a_idx == idx);
    assign rd_word   = fwd ? ((mem[idx] & ~wmask) | (hwdata & wmask)) : mem[idx];

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++)
            wmask[b*8 +: 8] = {8{(OFF_W'(b) >> a_size) == (a_off >> a_size)}};
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == S_WAIT) ? ((cnt == 4'(WAIT_STATES - 1)) ? S_LAST : S_WAIT)
                  : (state == S_ERR1) ? S_ERR2
                  : !accept           ? S_IDLE
                  : err               ? S_ERR1
                  : (WAIT_STATES > 0) ? S_WAIT : S_LAST;
    end

    always_comb begin
        hreadyout = !((state == S_WAIT) || (state == S_ERR1));
        hresp     = (state == S_ERR1) || (state == S_ERR2);
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            cnt     <= '0;
            a_write <= 1'b0;
            a_size  <= '0;
            a_off   <= '0;
            a_idx   <= '0;
            hrdata  <= '0;
        end else begin
            cnt <= (state == S_WAIT) ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                a_write <= hwrite;
                a_size  <= hsize;
                a_off   <= haddr[OFF_W-1:0];
                a_idx   <= idx;
                if (err)
                    hrdata <= '0;
                else if (!hwrite)
                    hrdata <= rd_word;
            end
        end
    end

    // memory is never reset; reset forces IDLE so an in-flight write cannot commit
    always_ff @(posedge hclk) begin
        if (state == S_LAST && a_write)
            mem[a_idx] <= (mem[a_idx] & ~wmask) | (hwdata & wmask);
    end
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb_ahb_lite_slave_mem: directed AHB-Lite bench over two slave instances (0 and 3 wait states) with a response scoreboard
module tb_ahb_lite_slave_mem;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    typedef struct {
        logic        resp;
        logic [31:0] data;
        logic        chk;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        tgt = 1'b0;
    logic        ro0, ro1, rs0, rs1;
    logic [31:0] rd0, rd1;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        dp_act = 1'b0;
    int          wcnt = 0;

    assign hready = tgt ? ro1 : ro0;
    assign hrdata = tgt ? rd1 : rd0;
    assign hresp  = tgt ? rs1 : rs0;

    always #5 hclk = ~hclk;

    ahb_lite_slave_mem #(.WAIT_STATES(0)) u0 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel & !tgt), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro0), .hrdata(rd0), .hresp(rs0)
    );

    ahb_lite_slave_mem #(.WAIT_STATES(3)) u1 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel & tgt), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro1), .hrdata(rd1), .hresp(rs1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // a cycle with hready high ends the pending data phase and takes the current address phase
    always @(negedge hclk) begin
        exp_t e;
        if (!hreset_n) begin
            dp_act = 1'b0;
            wcnt   = 0;
        end else if (!hready) begin
            if (dp_act) wcnt++;
        end else begin
            if (dp_act) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow: observed response with no expected entry");
                end else begin
                    e = sb.pop_front();
                    check("hresp", 32'(hresp), 32'(e.resp));
                    check("wait_cycles", wcnt, e.waits);
                    if (e.chk) check("hrdata", hrdata, e.data);
                end
            end
            dp_act = hsel;
            wcnt   = 0;
        end
    end

    task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd, input logic er,
                        input logic [31:0] ed, input logic ck, input int ew);
        logic rdy;
        int   n;
        hsel   = sel;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        if (sel) sb.push_back('{er, ed, ck, ew});
        n = 0;
        do begin
            @(negedge hclk);
            rdy = hready;
            @(posedge hclk);
            #1;
            n++;
        end while (!rdy && n < 64);
        if (!rdy) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed hready 0 for %0d cycles required 1", n);
        end
        hwdata = wd;
    endtask

    task automatic wr(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic er, input int ew);
        xfer(1'b1, tr, a, 1'b1, sz, d, er, 32'h0, 1'b0, ew);
    endtask

    task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] ed, input logic er, input int ew);
        xfer(1'b1, tr, a, 1'b0, sz, 32'h0, er, ed, 1'b1, ew);
    endtask

    task automatic idle();
        xfer(1'b0, IDLE, 32'h0, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    endtask

    initial begin
        repeat (3) @(posedge hclk);
        #1;
        check("rst_hreadyout0", 32'(ro0), 32'd1);
        check("rst_hresp0", 32'(rs0), 32'd0);
        check("rst_hrdata0", rd0, 32'h0);
        check("rst_hreadyout1", 32'(ro1), 32'd1);
        check("rst_hresp1", 32'(rs1), 32'd0);
        check("rst_hrdata1", rd1, 32'h0);
        hreset_n = 1'b1;
        @(posedge hclk);
        #1;

        // back-to-back write then read of the same word: read is forwarded
        wr(NSEQ, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
        rd(NSEQ, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
        idle();

        // byte lanes, then word and halfword reads
        wr(NSEQ, 32'h20, 3'd0, 32'h0000_0011, 1'b0, 0);
        wr(NSEQ, 32'h21, 3'd0, 32'h0000_2200, 1'b0, 0);
        wr(NSEQ, 32'h22, 3'd0, 32'h0033_0000, 1'b0, 0);
        wr(NSEQ, 32'h23, 3'd0, 32'h4400_0000, 1'b0, 0);
        rd(NSEQ, 32'h20, 3'd2, 32'h44332211, 1'b0, 0);
        rd(NSEQ, 32'h22, 3'd1, 32'h44332211, 1'b0, 0);
        idle();

        // misaligned halfword errors, memory unchanged, NONSEQ in ERR2 completes OKAY
        wr(NSEQ, 32'h00, 3'd2, 32'hA5A5A5A5, 1'b0, 0);
        wr(NSEQ, 32'h01, 3'd1, 32'hFFFFFFFF, 1'b1, 1);
        rd(NSEQ, 32'h00, 3'd2, 32'hA5A5A5A5, 1'b0, 0);
        rd(NSEQ, 32'h04, 3'd3, 32'h0, 1'b1, 1);
        idle();

        // out of range errors; IDLE and BUSY are zero-wait OKAY with no side effects
        wr(NSEQ, 32'h1000, 3'd2, 32'hFFFFFFFF, 1'b1, 1);
        rd(NSEQ, 32'h1000, 3'd2, 32'h0, 1'b1, 1);
        xfer(1'b1, IDLE, 32'h0, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 0);
        xfer(1'b1, BUSY, 32'h0, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 0);
        rd(NSEQ, 32'h00, 3'd2, 32'hA5A5A5A5, 1'b0, 0);
        rd(NSEQ, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 0);
        idle();
        idle();

        // three wait states per beat on an INCR4 burst
        tgt = 1'b1;
        for (int i = 0; i < 4; i++)
            wr(i == 0 ? NSEQ : SEQ, 32'h80 + 32'(4 * i), 3'd2, 32'h1000_0000 + 32'(i), 1'b0, 3);
        for (int i = 0; i < 4; i++)
            rd(i == 0 ? NSEQ : SEQ, 32'h80 + 32'(4 * i), 3'd2, 32'h1000_0000 + 32'(i), 1'b0, 3);
        idle();
        wr(NSEQ, 32'h40, 3'd2, 32'hCAFEF00D, 1'b0, 3);
        idle();
        idle();

        // reset during the wait states of a write aborts it
        hsel   = 1'b1;
        htrans = NSEQ;
        haddr  = 32'h40;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(posedge hclk);
        #1;
        hwdata = 32'h12345678;
        hsel   = 1'b0;
        htrans = IDLE;
        @(posedge hclk);
        #1;
        check("mid_wait_hreadyout", 32'(ro1), 32'd0);
        hreset_n = 1'b0;
        #1;
        check("async_rst_hreadyout", 32'(ro1), 32'd1);
        check("async_rst_hresp", 32'(rs1), 32'd0);
        check("async_rst_hrdata", rd1, 32'h0);
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        rd(NSEQ, 32'h40, 3'd2, 32'hCAFEF00D, 1'b0, 3);
        idle();
        idle();
        tgt = 1'b0;
        rd(NSEQ, 32'h20, 3'd2, 32'h44332211, 1'b0, 0);
        idle();
        idle();

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
